// File: rtl/i2s_pkg.sv
// i2s_pkg: shared mode constants and frame counter width helper for the I2S transmitter.
package i2s_pkg;
  localparam int I2S_MODE_PHILIPS = 0;
  localparam int I2S_MODE_LJ = 1;
  function automatic int cnt_width(input int slot_width);
    return $clog2(2 * slot_width);
  endfunction
endpackage

// File: rtl/i2s_frame_timer.sv
// i2s_frame_timer: free-running frame counter with registered word select and frame-start pulse.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = 26,
  localparam int CW = cnt_width(SLOT_WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [CW-1:0] n_o,
  output logic [CW-1:0] k_o,
  output logic          lr_o,
  output logic          fs_o
);
  localparam logic [CW-1:0] LAST = CW'(2 * SLOT_WIDTH - 1);
  localparam logic [CW-1:0] SLOT = CW'(SLOT_WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic lr_q, fs_q;
  // n_o/k_o describe the frame cycle whose outputs are registered at the coming edge
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    n_o = cnt_d;
    k_o = (cnt_d >= SLOT) ? cnt_d - SLOT : cnt_d;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= LAST;
      lr_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lr_q <= cnt_d >= SLOT;
      fs_q <= cnt_d == '0;
    end
  end
  assign lr_o = lr_q;
  assign fs_o = fs_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified stereo serialiser with a one-deep pending sample buffer.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH = 26,
  parameter int MODE = I2S_MODE_PHILIPS
) (
  input  logic                    BCLK,
  input  logic                    RESET,
  input  logic [SAMPLE_WIDTH-1:0] SAMPLE_L,
  input  logic [SAMPLE_WIDTH-1:0] SAMPLE_R,
  input  logic                    SAMPLE_VALID,
  output logic                    SAMPLE_READY,
  output logic                    DAC_LR_CLK,
  output logic                    DAC_DATA,
  output logic                    FRAME_START,
  output logic                    UNDERRUN
);
  localparam int CW = cnt_width(SLOT_WIDTH);
  localparam logic [CW-1:0] SLOT = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] OFS = CW'(MODE == I2S_MODE_LJ ? SAMPLE_WIDTH - 1 : SAMPLE_WIDTH);
  logic [CW-1:0] n, k;
  logic [SAMPLE_WIDTH-1:0] pend_l_q, pend_r_q, pend_l_d, pend_r_d;
  logic [SAMPLE_WIDTH-1:0] act_l_q, act_r_q, act_l_d, act_r_d, samp;
  logic pend_full_q, pend_full_d, primed_q, primed_d, data_q, data_d, under_q, under_d;
  logic fs_edge, accept, take;
  i2s_frame_timer #(.SLOT_WIDTH(SLOT_WIDTH)) u_timer (
    .clk_i(BCLK),
    .rst_i(RESET),
    .n_o  (n),
    .k_o  (k),
    .lr_o (DAC_LR_CLK),
    .fs_o (FRAME_START)
  );
  // bit select uses the next active pair so a fresh left MSB can go out at n=0
  always_comb begin
    fs_edge = n == '0;
    accept = SAMPLE_VALID & ~pend_full_q;
    take = fs_edge & pend_full_q;
    pend_l_d = accept ? SAMPLE_L : pend_l_q;
    pend_r_d = accept ? SAMPLE_R : pend_r_q;
    pend_full_d = accept | (pend_full_q & ~take);
    act_l_d = take ? pend_l_q : act_l_q;
    act_r_d = take ? pend_r_q : act_r_q;
    primed_d = primed_q | take;
    under_d = fs_edge & ~pend_full_q & primed_q;
    samp = (n >= SLOT) ? act_r_d : act_l_d;
    data_d = (k <= OFS) && (MODE == I2S_MODE_LJ || k != '0)
             && |(samp & (SAMPLE_WIDTH'(1) << (OFS - k)));
  end
  always_ff @(posedge BCLK or posedge RESET) begin
    if (RESET) begin
      pend_l_q <= '0;
      pend_r_q <= '0;
      act_l_q <= '0;
      act_r_q <= '0;
      pend_full_q <= 1'b0;
      primed_q <= 1'b0;
      data_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      act_l_q <= act_l_d;
      act_r_q <= act_r_d;
      pend_full_q <= pend_full_d;
      primed_q <= primed_d;
      data_q <= data_d;
      under_q <= under_d;
    end
  end
  assign SAMPLE_READY = ~pend_full_q;
  assign DAC_DATA = data_q;
  assign UNDERRUN = under_q;
endmodule
